frame_bank_scheduler: RTL
=========================

# frame_bank_scheduler

Triple-buffer scheduler for the shared frame RAM. It sits between `rgb_logic` (writer) and `framebuffer` (reader) on the `ram` address paths. It rebases each side's local frame address into one of three RAM banks. It rotates bank ownership on writer frame completion and on reader turn start (`position_sync`), so the display never reads a frame that is being written.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: width of all RAM address ports.
- `BANK_DEPTH`, 20480: words per bank; bank `b` base address = `b*BANK_DEPTH`. `3*BANK_DEPTH` must fit in `ADDR_WIDTH`.

Ports:
- `clk`  in  1  system clock (66 MHz domain).
- `nrst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `w_enable_in`  in  1  writer write strobe.
- `w_addr_in`  in  ADDR_WIDTH  writer local address (0..BANK_DEPTH-1).
- `w_frame_done`  in  1  one-cycle pulse: the writer's current frame is complete.
- `w_enable_out`  out  1  registered write strobe to `ram`.
- `w_addr_out`  out  ADDR_WIDTH  registered global write address.
- `r_addr_in`  in  ADDR_WIDTH  reader local address.
- `r_frame_sync`  in  1  one-cycle pulse at reader turn start (`position_sync`).
- `r_addr_out`  out  ADDR_WIDTH  registered global read address.
- `stream_ready`  out  1  the reader bank holds a complete frame.
- `w_bank`, `r_bank`  out  2 each  current writer and reader bank indices (debug).
- `frames_dropped`  out  8  saturating count of completed frames that were never displayed.
- `addr_error`  out  1  sticky flag: an out-of-range local address was seen.

## Operation
- State: `w_bank`, `p_bank` (pending/free), `r_bank`, `pending_valid`. The three indices are always a permutation of {0,1,2}.
- Reset values: `w_bank`=0, `p_bank`=1, `r_bank`=2, `pending_valid`=0, `stream_ready`=0, `frames_dropped`=0, `addr_error`=0, `w_enable_out`=0, both addr outs=0.
- `w_frame_done` only:
  - swap `w_bank`↔`p_bank`;
  - `pending_valid`←1;
  - if `pending_valid` was already 1, `frames_dropped`+=1 (saturates at 255).
- `r_frame_sync` only:
  - if `pending_valid`: swap `r_bank`↔`p_bank`, `pending_valid`←0, `stream_ready`←1 (stays 1 until reset);
  - otherwise no change; the reader redisplays its current bank.
- Both pulses in the same cycle:
  - new `r_bank`=old `w_bank`, new `w_bank`=old `p_bank`, new `p_bank`=old `r_bank`;
  - `pending_valid`←0, `stream_ready`←1;
  - if old `pending_valid`=1, `frames_dropped`+=1.
- Write path:
  - `w_addr_in` < `BANK_DEPTH`: `w_addr_out`=base(`w_bank`)+`w_addr_in`, `w_enable_out`=`w_enable_in`.
  - Out of range with `w_enable_in`=1: the write is suppressed (`w_enable_out`=0) and `addr_error`←1.
- Read path:
  - in range: `r_addr_out`=base(`r_bank`)+`r_addr_in`;
  - out of range: `r_addr_out`=base(`r_bank`) and `addr_error`←1.
- Base computation is a constant mux over the bank index; no multiplier. Bank index 3 is unreachable.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronously). Any partial frame is discarded.

## Timing
- Address and enable outputs have 1-cycle latency. Each output uses the bank index valid in the cycle its input was sampled.
- A write sampled in the same cycle as `w_frame_done` goes to the old `w_bank`; the new bank applies from the next input cycle.
- A read sampled in the same cycle as `r_frame_sync` uses the old `r_bank`; the new bank applies from the next cycle.
- Bank state, `pending_valid`, `stream_ready` and `frames_dropped` update on the clock edge that samples the pulse. They are visible the following cycle.
- Pulses longer than one cycle are treated as repeated events; callers must supply single-cycle pulses.

## Structure
- Shared package `spirose_pkg`:
  - `bank_t` (logic [1:0]);
  - `NB_BANKS`=3;
  - reset indices `W_BANK_RST`=0, `P_BANK_RST`=1, `R_BANK_RST`=2.
- Sub-module `bank_addr_map`: combinational range check plus base add, parameterised by `ADDR_WIDTH`/`BANK_DEPTH`. It is instantiated once for the write path and once for the read path; the registers live in the top.

## Test plan
- Reset release, write local 5: `w_addr_out`=5 and `w_enable_out`=1 one cycle later; `stream_ready`=0.
- `w_frame_done` then `r_frame_sync`: banks go w=1,p=0 → r=0,p=2; `stream_ready`=1. A read of local 7 yields 7; a write of local 7 yields `BANK_DEPTH`+7.
- Two `w_frame_done` pulses with no sync: `frames_dropped`=1. After 300 such extra frames it saturates at 255.
- `r_frame_sync` with `pending_valid`=0: all banks unchanged, `stream_ready` unchanged.
- Simultaneous pulses from reset state plus one prior done (w=1,p=0,r=2,pending=1): result r=1, w=0, p=2, pending=0, `frames_dropped` incremented.
- Write to local `BANK_DEPTH`: `w_enable_out`=0 and `addr_error`=1. Assert `nrst` mid-frame: all outputs return to their reset values.

Source files
------------

// File: rtl/frame_bank_scheduler_pkg.sv
// Shared types and constants for the triple-buffered frame RAM scheduler.
package spirose_pkg;

  typedef logic [1:0] bank_t;

  localparam int NB_BANKS = 3;

  localparam bank_t W_BANK_RST = 2'd0;
  localparam bank_t P_BANK_RST = 2'd1;
  localparam bank_t R_BANK_RST = 2'd2;

endpackage : spirose_pkg

// File: rtl/frame_bank_scheduler_addr_map.sv
// Combinational bank rebasing: range-checks a local frame address and adds
// the base of the selected bank. Out-of-range addresses collapse to the base.
import spirose_pkg::*;

module bank_addr_map #(
  parameter int ADDR_WIDTH = 32,
  parameter int BANK_DEPTH = 20480
) (
  input  bank_t                 i_bank,
  input  logic [ADDR_WIDTH-1:0] i_localAddr,
  output logic [ADDR_WIDTH-1:0] o_globalAddr,
  output logic                  o_inRange
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(BANK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE2 = ADDR_WIDTH'(2 * BANK_DEPTH);

  logic [ADDR_WIDTH-1:0] w_base;

  // Bank base is a constant mux; index 3 never occurs and maps to zero.
  always_comb begin
    w_base = '0;
    case (i_bank)
      2'd1:    w_base = DEPTH;
      2'd2:    w_base = BASE2;
      default: w_base = '0;
    endcase
  end

  // Range check and rebase; an illegal offset is dropped so the access stays inside its bank.
  always_comb begin
    o_inRange    = (i_localAddr < DEPTH);
    o_globalAddr = o_inRange ? (w_base + i_localAddr) : w_base;
  end

endmodule : bank_addr_map

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler between the frame writer and the display reader.
// Rotates bank ownership on writer frame completion and reader turn start,
// and registers the rebased RAM addresses with one cycle of latency.
import spirose_pkg::*;

module frame_bank_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int BANK_DEPTH = 20480
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  w_enable_in,
  input  logic [ADDR_WIDTH-1:0] w_addr_in,
  input  logic                  w_frame_done,
  output logic                  w_enable_out,
  output logic [ADDR_WIDTH-1:0] w_addr_out,
  input  logic [ADDR_WIDTH-1:0] r_addr_in,
  input  logic                  r_frame_sync,
  output logic [ADDR_WIDTH-1:0] r_addr_out,
  output logic                  stream_ready,
  output bank_t                 w_bank,
  output bank_t                 r_bank,
  output logic [7:0]            frames_dropped,
  output logic                  addr_error
);

  bank_t                 r_wBank, r_pBank, r_rBank;
  logic                  r_pendingValid;
  logic                  r_streamReady;
  logic [7:0]            r_framesDropped;
  logic                  r_addrError;
  logic                  r_wEnableOut;
  logic [ADDR_WIDTH-1:0] r_wAddrOut;
  logic [ADDR_WIDTH-1:0] r_rAddrOut;

  bank_t                 w_nextWBank, w_nextPBank, w_nextRBank;
  logic                  w_nextPending;
  logic                  w_nextReady;
  logic [7:0]            w_nextDropped;
  logic                  w_bumpDrop;
  logic                  w_nextError;
  logic [ADDR_WIDTH-1:0] w_wrGlobal, w_rdGlobal;
  logic                  w_wrInRange, w_rdInRange;

  bank_addr_map #(.ADDR_WIDTH(ADDR_WIDTH), .BANK_DEPTH(BANK_DEPTH)) u_wrMap (
    .i_bank      (r_wBank),
    .i_localAddr (w_addr_in),
    .o_globalAddr(w_wrGlobal),
    .o_inRange   (w_wrInRange)
  );

  bank_addr_map #(.ADDR_WIDTH(ADDR_WIDTH), .BANK_DEPTH(BANK_DEPTH)) u_rdMap (
    .i_bank      (r_rBank),
    .i_localAddr (r_addr_in),
    .o_globalAddr(w_rdGlobal),
    .o_inRange   (w_rdInRange)
  );

  // Bank rotation: a finished frame becomes pending; a reader sync claims it if one is waiting.
  always_comb begin
    w_nextWBank   = r_wBank;
    w_nextPBank   = r_pBank;
    w_nextRBank   = r_rBank;
    w_nextPending = r_pendingValid;
    w_nextReady   = r_streamReady;
    w_bumpDrop    = w_frame_done && r_pendingValid && (r_framesDropped != 8'hFF);
    w_nextDropped = w_bumpDrop ? (r_framesDropped + 8'd1) : r_framesDropped;
    case ({w_frame_done, r_frame_sync})
      2'b10: begin
        w_nextWBank   = r_pBank;
        w_nextPBank   = r_wBank;
        w_nextPending = 1'b1;
      end
      2'b01: begin
        if (r_pendingValid) begin
          w_nextRBank   = r_pBank;
          w_nextPBank   = r_rBank;
          w_nextPending = 1'b0;
          w_nextReady   = 1'b1;
        end
      end
      2'b11: begin
        w_nextRBank   = r_wBank;
        w_nextWBank   = r_pBank;
        w_nextPBank   = r_rBank;
        w_nextPending = 1'b0;
        w_nextReady   = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The error flag is sticky: an illegal write attempt or any illegal read offset latches it.
  always_comb begin
    w_nextError = r_addrError | (w_enable_in & ~w_wrInRange) | ~w_rdInRange;
  end

  // Scheduler state register; reset drops any partially written frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wBank         <= W_BANK_RST;
      r_pBank         <= P_BANK_RST;
      r_rBank         <= R_BANK_RST;
      r_pendingValid  <= 1'b0;
      r_streamReady   <= 1'b0;
      r_framesDropped <= 8'd0;
      r_addrError     <= 1'b0;
    end else begin
      r_wBank         <= w_nextWBank;
      r_pBank         <= w_nextPBank;
      r_rBank         <= w_nextRBank;
      r_pendingValid  <= w_nextPending;
      r_streamReady   <= w_nextReady;
      r_framesDropped <= w_nextDropped;
      r_addrError     <= w_nextError;
    end
  end

  // Output address registers, rebased with the banks held before this edge's rotation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wEnableOut <= 1'b0;
      r_wAddrOut   <= '0;
      r_rAddrOut   <= '0;
    end else begin
      r_wEnableOut <= w_enable_in & w_wrInRange;
      r_wAddrOut   <= w_wrGlobal;
      r_rAddrOut   <= w_rdGlobal;
    end
  end

  assign w_enable_out   = r_wEnableOut;
  assign w_addr_out     = r_wAddrOut;
  assign r_addr_out     = r_rAddrOut;
  assign stream_ready   = r_streamReady;
  assign w_bank         = r_wBank;
  assign r_bank         = r_rBank;
  assign frames_dropped = r_framesDropped;
  assign addr_error     = r_addrError;

endmodule : frame_bank_scheduler
